// File: rtl/vx_mem_perf_monitor_if.sv
// Memory request/response handshake bundle observed by vx_mem_perf_monitor.
// master: cluster side driving requests and accepting responses.
// slave: memory side accepting requests and returning responses.
// monitor: passive observer, every signal is an input.
interface vx_mem_perf_monitor_if #(
    parameter int NUM_REQS = 1
);
    logic [NUM_REQS-1:0] mem_req_valid;
    logic [NUM_REQS-1:0] mem_req_ready;
    logic [NUM_REQS-1:0] mem_req_rw;
    logic [NUM_REQS-1:0] mem_rsp_valid;
    logic [NUM_REQS-1:0] mem_rsp_ready;

    modport master (
        output mem_req_valid,
        output mem_req_rw,
        output mem_rsp_ready,
        input  mem_req_ready,
        input  mem_rsp_valid
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_rw,
        input  mem_rsp_ready,
        output mem_req_ready,
        output mem_rsp_valid
    );

    modport monitor (
        input mem_req_valid,
        input mem_req_ready,
        input mem_req_rw,
        input mem_rsp_valid,
        input mem_rsp_ready
    );
endinterface

// File: rtl/vx_mem_perf_monitor.sv
// Passive memory performance monitor.
// Counts accepted reads and writes on every request port and, when
// MEM_PERF_LATENCY_EN is defined, tracks outstanding reads and accumulates
// them every cycle into a total read latency. Without MEM_PERF_LATENCY_EN
// the tracker and accumulator are absent and mem_latency / pend_err read 0.
module vx_mem_perf_monitor #(
    parameter int NUM_REQS  = 1,
    parameter int CTR_BITS  = 44,
    parameter int PEND_BITS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        perf_clear,
    vx_mem_perf_monitor_if.monitor      bus,
    output logic [CTR_BITS-1:0]         mem_reads,
    output logic [CTR_BITS-1:0]         mem_writes,
    output logic [CTR_BITS-1:0]         mem_latency,
    output logic                        pend_err
);

    localparam int CNT_W = $clog2(NUM_REQS + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REQS-1:0] bits);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            c = c + CNT_W'(bits[i]);
        end
        return c;
    endfunction

    logic [NUM_REQS-1:0] req_fire;
    logic [NUM_REQS-1:0] rd_fire;
    logic [NUM_REQS-1:0] wr_fire;
    logic [CNT_W-1:0]    nr;
    logic [CNT_W-1:0]    nw;

    assign req_fire = bus.mem_req_valid & bus.mem_req_ready;
    assign rd_fire  = req_fire & ~bus.mem_req_rw;
    assign wr_fire  = req_fire &  bus.mem_req_rw;
    assign nr       = popcount(rd_fire);
    assign nw       = popcount(wr_fire);

    // Request counters; clear discards the current cycle's increments.
    always_ff @(posedge clk) begin
        if (reset || perf_clear) begin
            mem_reads  <= '0;
            mem_writes <= '0;
        end else begin
            mem_reads  <= mem_reads  + CTR_BITS'(nr);
            mem_writes <= mem_writes + CTR_BITS'(nw);
        end
    end

`ifdef MEM_PERF_LATENCY_EN
    // Sum is kept wide enough that pending_max + NUM_REQS cannot wrap,
    // so overflow is never mistaken for underflow.
    localparam int SW = PEND_BITS + CNT_W + 1;
    localparam logic signed [SW-1:0] PEND_MAX_S = SW'({PEND_BITS{1'b1}});

    logic [NUM_REQS-1:0]   rsp_fire;
    logic [CNT_W-1:0]      ns;
    logic [PEND_BITS-1:0]  pending;
    logic [PEND_BITS-1:0]  pend_next;
    logic signed [SW-1:0]  pend_sum;
    logic                  pend_fault;

    assign rsp_fire = bus.mem_rsp_valid & bus.mem_rsp_ready;
    assign ns       = popcount(rsp_fire);

    // Next outstanding-read count with clamp at both ends.
    always_comb begin
        pend_sum   = SW'(pending) + SW'(nr) - SW'(ns);
        pend_next  = pend_sum[PEND_BITS-1:0];
        pend_fault = 1'b0;
        if (pend_sum[SW-1]) begin
            pend_next  = '0;
            pend_fault = 1'b1;
        end else if (pend_sum > PEND_MAX_S) begin
            pend_next  = '1;
            pend_fault = 1'b1;
        end
    end

    // Tracker survives perf_clear so in-flight reads still retire cleanly;
    // the accumulator adds the pre-update pending value.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            mem_latency <= '0;
            pend_err    <= 1'b0;
        end else begin
            pending <= pend_next;
            if (perf_clear) begin
                mem_latency <= '0;
                pend_err    <= 1'b0;
            end else begin
                mem_latency <= mem_latency + CTR_BITS'(pending);
                pend_err    <= pend_err | pend_fault;
            end
        end
    end
`else
    logic unused_rsp;

    assign unused_rsp  = ^{bus.mem_rsp_valid, bus.mem_rsp_ready};
    assign mem_latency = '0;
    assign pend_err    = 1'b0;
`endif

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Self-checking bench for vx_mem_perf_monitor.
// dut1: single port, full-width counters, checked cycle by cycle against a
// behavioural model through an expected-value queue.
// dut4: four ports, 4-bit counters and a 2-bit tracker, checked from a
// table of hand-computed vectors (wrap and saturation corners).
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module tb_vx_mem_perf_monitor;

    localparam int CTR1 = `PERF_CTR_BITS;
`ifdef MEM_PERF_LATENCY_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    logic clr1;
    logic clr4;

    vx_mem_perf_monitor_if #(.NUM_REQS(1)) bus1();
    vx_mem_perf_monitor_if #(.NUM_REQS(4)) bus4();

    logic [CTR1-1:0] reads1, writes1, lat1;
    logic            err1;
    logic [3:0]      reads4, writes4, lat4;
    logic            err4;

    vx_mem_perf_monitor #(.NUM_REQS(1), .CTR_BITS(CTR1), .PEND_BITS(8)) dut1 (
        .clk(clk), .reset(reset), .perf_clear(clr1), .bus(bus1),
        .mem_reads(reads1), .mem_writes(writes1), .mem_latency(lat1), .pend_err(err1)
    );

    vx_mem_perf_monitor #(.NUM_REQS(4), .CTR_BITS(4), .PEND_BITS(2)) dut4 (
        .clk(clk), .reset(reset), .perf_clear(clr4), .bus(bus4),
        .mem_reads(reads4), .mem_writes(writes4), .mem_latency(lat4), .pend_err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [CTR1-1:0] reads;
        logic [CTR1-1:0] writes;
        logic [CTR1-1:0] lat;
        logic            err;
        logic [7:0]      pend;
    } exp_t;

    exp_t sb[$];

    logic [CTR1-1:0] m_reads, m_writes, m_lat;
    logic            m_err;
    int              m_pend;

    typedef struct {
        logic [3:0] v, r, rw, sv, sr;
        logic       clr;
        int         reads, writes, lat;
        logic       err;
        int         pend;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive dut1 inputs, advance the model, push its prediction,
    // then pop and compare once the edge has been taken.
    task automatic step(input logic rs, input logic cl, input logic v, input logic r,
                        input logic rw, input logic sv, input logic sr);
        exp_t e;
        int   sum;
        logic f;
        logic nr, nw, ns;
        logic [CTR1-1:0] nl;
        reset = rs;
        clr1  = cl;
        bus1.mem_req_valid = v;
        bus1.mem_req_ready = r;
        bus1.mem_req_rw    = rw;
        bus1.mem_rsp_valid = sv;
        bus1.mem_rsp_ready = sr;
        nr = v & r & ~rw;
        nw = v & r & rw;
        ns = sv & sr;
        if (rs) begin
            m_reads = '0; m_writes = '0; m_lat = '0; m_err = 1'b0; m_pend = 0;
        end else begin
            sum = m_pend + int'(nr) - int'(ns);
            f   = 1'b0;
            nl  = m_lat + CTR1'(m_pend);
            if (sum < 0) begin
                sum = 0; f = 1'b1;
            end else if (sum > 255) begin
                sum = 255; f = 1'b1;
            end
            if (cl) begin
                m_reads = '0; m_writes = '0; m_lat = '0; m_err = 1'b0;
            end else begin
                m_reads  = m_reads  + CTR1'(nr);
                m_writes = m_writes + CTR1'(nw);
                m_lat    = nl;
                m_err    = m_err | f;
            end
            m_pend = sum;
        end
        e.reads  = m_reads;
        e.writes = m_writes;
        e.lat    = LAT_EN ? m_lat : '0;
        e.err    = LAT_EN ? m_err : 1'b0;
        e.pend   = 8'(m_pend);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("reads1", 64'(reads1), 64'(e.reads));
        chk("writes1", 64'(writes1), 64'(e.writes));
        chk("lat1", 64'(lat1), 64'(e.lat));
        chk("err1", 64'(err1), 64'(e.err));
`ifdef MEM_PERF_LATENCY_EN
        chk("pend1", 64'(dut1.pending), 64'(e.pend));
`endif
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [CTR1-1:0] base;

        //            v        r        rw       sv       sr       clr   rd wr lat err pend
        tbl[0]  = '{4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2, 2, 0,  1'b0, 2};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2, 2, 2,  1'b0, 2};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 1'b0, 2, 2, 4,  1'b0, 0};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, 2, 2, 4,  1'b1, 0};
        tbl[4]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 0, 0,  1'b0, 1};
        tbl[5]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4, 0, 1,  1'b1, 3};
        tbl[6]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 5, 0, 4,  1'b1, 3};
        tbl[7]  = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 5, 4, 7,  1'b1, 3};
        tbl[8]  = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 5, 8, 10, 1'b1, 3};
        tbl[9]  = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 5, 12, 13, 1'b1, 3};
        tbl[10] = '{4'b0111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 5, 15, 0, 1'b1, 3};
        tbl[11] = '{4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1'b0, 5, 1, 3,  1'b1, 3};
        tbl[12] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0, 6, 1, 6,  1'b1, 3};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0, 6, 1, 9,  1'b1, 0};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 6, 1, 9,  1'b1, 0};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 0, 0,  1'b0, 0};

        reset = 1'b1; clr1 = 1'b0; clr4 = 1'b0;
        bus1.mem_req_valid = '0; bus1.mem_req_ready = '0; bus1.mem_req_rw = '0;
        bus1.mem_rsp_valid = '0; bus1.mem_rsp_ready = '0;
        bus4.mem_req_valid = '0; bus4.mem_req_ready = '0; bus4.mem_req_rw = '0;
        bus4.mem_rsp_valid = '0; bus4.mem_rsp_ready = '0;
        m_reads = '0; m_writes = '0; m_lat = '0; m_err = 1'b0; m_pend = 0;
        @(posedge clk);
        #1;

        // Reset state for both instances.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_reads4", 64'(reads4), 64'd0);
        chk("rst_writes4", 64'(writes4), 64'd0);
        chk("rst_lat4", 64'(lat4), 64'd0);
        chk("rst_err4", 64'(err4), 64'd0);

        // Read accepted at cycle 10, response at cycle 14.
        cyc = 0;
        while (cyc < 10) idle();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        while (cyc < 14) idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("lat_scn_reads", 64'(reads1), 64'd1);
        chk("lat_scn_latency", 64'(lat1), LAT_EN ? 64'd4 : 64'd0);
        chk("lat_scn_err", 64'(err1), 64'd0);

        // Four-port vectors.
        for (int i = 0; i < 16; i++) begin
            bus4.mem_req_valid = tbl[i].v;
            bus4.mem_req_ready = tbl[i].r;
            bus4.mem_req_rw    = tbl[i].rw;
            bus4.mem_rsp_valid = tbl[i].sv;
            bus4.mem_rsp_ready = tbl[i].sr;
            clr4               = tbl[i].clr;
            idle();
            chk($sformatf("tbl%0d_reads", i), 64'(reads4), 64'(tbl[i].reads));
            chk($sformatf("tbl%0d_writes", i), 64'(writes4), 64'(tbl[i].writes));
            chk($sformatf("tbl%0d_lat", i), 64'(lat4), LAT_EN ? 64'(tbl[i].lat) : 64'd0);
            chk($sformatf("tbl%0d_err", i), 64'(err4), LAT_EN ? 64'(tbl[i].err) : 64'd0);
`ifdef MEM_PERF_LATENCY_EN
            chk($sformatf("tbl%0d_pend", i), 64'(dut4.pending), 64'(tbl[i].pend));
`endif
        end
        bus4.mem_req_valid = '0; bus4.mem_req_ready = '0; bus4.mem_req_rw = '0;
        bus4.mem_rsp_valid = '0; bus4.mem_rsp_ready = '0;
        clr4 = 1'b0;

        // Back-pressure: 5 stalled cycles then one accept counts once.
        base = reads1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_reads_delta", 64'(reads1 - base), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Underflow then clear.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("uflow_err", 64'(err1), LAT_EN ? 64'd1 : 64'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_err", 64'(err1), 64'd0);
        chk("clr_reads", 64'(reads1), 64'd0);
        chk("clr_writes", 64'(writes1), 64'd0);
        chk("clr_lat", 64'(lat1), 64'd0);

        // Reset mid-traffic: late response for a pre-reset read flags an error.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_mid_err", 64'(err1), LAT_EN ? 64'd1 : 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
